// File: rtl/riscv_arb_pkg.sv
// rtl/riscv_arb_pkg.sv - shared types and defaults for the instruction/data memory arbiter
package riscv_arb_pkg;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_e;

    // Fetches always read a full word
    localparam logic [3:0] FETCH_BE = 4'hF;

    localparam int MAX_OUTST_DEF    = 2;
    localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/riscv_arb_owner_fifo.sv
// rtl/riscv_arb_owner_fifo.sv - in-order FIFO of owner IDs for granted-but-unanswered transactions
module riscv_arb_owner_fifo
    import riscv_arb_pkg::*;
#(
    parameter int DEPTH = MAX_OUTST_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  arb_owner_e push_owner,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output arb_owner_e head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    arb_owner_e        slots [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = slots[rd_ptr];

    // Owner storage; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_owner;
        end
    end

    // Pointers wrap modulo DEPTH; simultaneous push and pop leaves occupancy unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - fetch/data arbiter onto one memory port; RISCV_ARB_ROUND_ROBIN_EN selects round-robin policy
module riscv_mem_arbiter
    import riscv_arb_pkg::*;
#(
    parameter int MAX_OUTST    = MAX_OUTST_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_instr_req,
    input  logic [31:0] i_instr_addr,
    output logic        o_instr_gnt,
    output logic        o_instr_rvalid,
    output logic [31:0] o_instr_rdata,
    input  logic        i_data_req,
    input  logic        i_data_we,
    input  logic [3:0]  i_data_be,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_wdata,
    output logic        o_data_gnt,
    output logic        o_data_rvalid,
    output logic [31:0] o_data_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_err
);

    arb_owner_e sel;
    arb_owner_e policy_sel;
    arb_owner_e lock_owner;
    arb_owner_e fifo_head;
    logic       lock_valid;
    logic       sel_req;
    logic       fifo_full;
    logic       fifo_empty;
    logic       mem_gnt_any;
    logic       resp_ok;

`ifdef RISCV_ARB_ROUND_ROBIN_EN
    arb_owner_e last_gnt;

    // Remember who won last so the other side wins the next contested cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= OWN_DATA;
        end else if (o_instr_gnt) begin
            last_gnt <= OWN_INSTR;
        end else if (o_data_gnt) begin
            last_gnt <= OWN_DATA;
        end
    end

    // Alternate on contention, otherwise serve whoever is asking
    always_comb begin
        policy_sel = OWN_INSTR;
        if (i_instr_req && i_data_req) begin
            policy_sel = (last_gnt == OWN_DATA) ? OWN_INSTR : OWN_DATA;
        end else if (i_data_req) begin
            policy_sel = OWN_DATA;
        end
    end
`else
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;
    logic          fetch_starved;

    assign fetch_starved = (starve_cnt == STARVE_MAX);

    // Count cycles a waiting fetch loses to data; saturate at the limit
    always_ff @(posedge clk) begin
        if (rst || !i_instr_req || o_instr_gnt) begin
            starve_cnt <= '0;
        end else if (o_data_gnt && !fetch_starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Data has priority unless a fetch has been starved long enough
    always_comb begin
        policy_sel = OWN_INSTR;
        if (fetch_starved && i_instr_req) begin
            policy_sel = OWN_INSTR;
        end else if (i_data_req) begin
            policy_sel = OWN_DATA;
        end
    end
`endif

    // An outstanding ungranted request keeps its owner until accepted
    always_comb begin
        sel = policy_sel;
        if (lock_valid) begin
            sel = lock_owner;
        end
    end

    assign sel_req     = (sel == OWN_DATA) ? i_data_req : i_instr_req;
    assign o_mem_req   = sel_req & ~fifo_full;
    assign mem_gnt_any = o_mem_req & i_mem_gnt;
    assign o_instr_gnt = mem_gnt_any & (sel == OWN_INSTR);
    assign o_data_gnt  = mem_gnt_any & (sel == OWN_DATA);

    assign o_mem_we    = (sel == OWN_DATA) ? i_data_we    : 1'b0;
    assign o_mem_be    = (sel == OWN_DATA) ? i_data_be    : FETCH_BE;
    assign o_mem_addr  = (sel == OWN_DATA) ? i_data_addr  : i_instr_addr;
    assign o_mem_wdata = (sel == OWN_DATA) ? i_data_wdata : 32'h0;

    // Hold the selection while a presented request waits for the downstream grant
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_valid <= 1'b0;
            lock_owner <= OWN_DATA;
        end else if (o_mem_req && !i_mem_gnt) begin
            lock_valid <= 1'b1;
            lock_owner <= sel;
        end else begin
            lock_valid <= 1'b0;
        end
    end

    riscv_arb_owner_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_owner_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (mem_gnt_any),
        .push_owner (sel),
        .pop        (i_mem_rvalid),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (fifo_head)
    );

    assign resp_ok        = i_mem_rvalid & ~fifo_empty;
    assign o_instr_rvalid = resp_ok & (fifo_head == OWN_INSTR);
    assign o_data_rvalid  = resp_ok & (fifo_head == OWN_DATA);
    assign o_instr_rdata  = i_mem_rdata;
    assign o_data_rdata   = i_mem_rdata;

    // A response with nothing outstanding is a protocol violation; sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            o_err <= 1'b0;
        end else if (i_mem_rvalid && fifo_empty) begin
            o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - directed scoreboard bench for riscv_mem_arbiter
module tb_riscv_mem_arbiter;
    import riscv_arb_pkg::*;

    typedef struct {
        logic        own;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_instr_req;
    logic [31:0] i_instr_addr;
    logic        o_instr_gnt;
    logic        o_instr_rvalid;
    logic [31:0] o_instr_rdata;
    logic        i_data_req;
    logic        i_data_we;
    logic [3:0]  i_data_be;
    logic [31:0] i_data_addr;
    logic [31:0] i_data_wdata;
    logic        o_data_gnt;
    logic        o_data_rvalid;
    logic [31:0] o_data_rdata;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_err;

    int   total = 0;
    int   bad   = 0;
    ent_t sb[$];

    always #5 clk = ~clk;

    riscv_mem_arbiter #(
        .MAX_OUTST    (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_instr_req    (i_instr_req),
        .i_instr_addr   (i_instr_addr),
        .o_instr_gnt    (o_instr_gnt),
        .o_instr_rvalid (o_instr_rvalid),
        .o_instr_rdata  (o_instr_rdata),
        .i_data_req     (i_data_req),
        .i_data_we      (i_data_we),
        .i_data_be      (i_data_be),
        .i_data_addr    (i_data_addr),
        .i_data_wdata   (i_data_wdata),
        .o_data_gnt     (o_data_gnt),
        .o_data_rvalid  (o_data_rvalid),
        .o_data_rdata   (o_data_rdata),
        .o_mem_req      (o_mem_req),
        .o_mem_we       (o_mem_we),
        .o_mem_be       (o_mem_be),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .i_mem_gnt      (i_mem_gnt),
        .i_mem_rvalid   (i_mem_rvalid),
        .i_mem_rdata    (i_mem_rdata),
        .o_err          (o_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_instr_req  = 1'b0;
        i_instr_addr = 32'h0;
        i_data_req   = 1'b0;
        i_data_we    = 1'b0;
        i_data_be    = 4'h0;
        i_data_addr  = 32'h0;
        i_data_wdata = 32'h0;
        i_mem_gnt    = 1'b0;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Compare grants; every expected grant queues the response the bench will later return
    task automatic grants(input string tag, input logic exp_i, input logic exp_d, input logic [31:0] rdata);
        ent_t e;
        #1;
        chk({tag, "_instr_gnt"}, {31'h0, o_instr_gnt}, {31'h0, exp_i});
        chk({tag, "_data_gnt"},  {31'h0, o_data_gnt},  {31'h0, exp_d});
        if (exp_i) begin
            e.own = OWN_INSTR;
            e.data = rdata;
            sb.push_back(e);
        end
        if (exp_d) begin
            e.own = OWN_DATA;
            e.data = rdata;
            sb.push_back(e);
        end
    endtask

    // Return the oldest outstanding response and check where it is routed
    task automatic respond(input string tag);
        ent_t e;
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL %s_sb_empty: observed=0 expected=nonzero", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = e.data;
            #1;
            chk({tag, "_instr_rvalid"}, {31'h0, o_instr_rvalid}, {31'h0, e.own == OWN_INSTR});
            chk({tag, "_data_rvalid"},  {31'h0, o_data_rvalid},  {31'h0, e.own == OWN_DATA});
            chk({tag, "_rdata"}, (e.own == OWN_DATA) ? o_data_rdata : o_instr_rdata, e.data);
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_err", {31'h0, o_err}, 32'h0);
        chk("reset_mem_req", {31'h0, o_mem_req}, 32'h0);
        grants("reset", 1'b0, 1'b0, 32'h0);

        // Single fetch, response two cycles later
        i_instr_req = 1'b1; i_instr_addr = 32'h100; i_mem_gnt = 1'b1;
        #1;
        chk("fetch_mem_req", {31'h0, o_mem_req}, 32'h1);
        chk("fetch_addr", o_mem_addr, 32'h100);
        chk("fetch_we", {31'h0, o_mem_we}, 32'h0);
        chk("fetch_be", {28'h0, o_mem_be}, 32'hF);
        grants("fetch", 1'b1, 1'b0, 32'hDEADBEEF);
        tick();
        tick();
        respond("fetch_resp");
        chk("fetch_rdata_const", o_instr_rdata, 32'hDEADBEEF);

        // Both request every cycle: D,D,D,D,I repeating
        for (int i = 0; i < 10; i++) begin
            tick();
            i_instr_req = 1'b1; i_instr_addr = 32'h400;
            i_data_req  = 1'b1; i_data_addr  = 32'h800;
            i_mem_gnt   = 1'b1;
            if (i > 0) respond("starve_resp");
            grants("starve", (i % 5) == 4, (i % 5) != 4, 32'hC000_0000 + 32'(i));
            chk("starve_addr", o_mem_addr, ((i % 5) == 4) ? 32'h400 : 32'h800);
        end
        tick();
        respond("starve_drain");

        // Store held ungranted for 3 cycles while fetch rises
        for (int k = 0; k < 3; k++) begin
            tick();
            i_data_req = 1'b1; i_data_we = 1'b1; i_data_be = 4'h3;
            i_data_addr = 32'h200; i_data_wdata = 32'h55;
            i_instr_req = (k > 0); i_instr_addr = 32'h300;
            #1;
            chk("lock_mem_req", {31'h0, o_mem_req}, 32'h1);
            chk("lock_we", {31'h0, o_mem_we}, 32'h1);
            chk("lock_addr", o_mem_addr, 32'h200);
            chk("lock_be", {28'h0, o_mem_be}, 32'h3);
            grants("lock", 1'b0, 1'b0, 32'h0);
        end
        tick();
        i_data_req = 1'b1; i_data_we = 1'b1; i_data_be = 4'h3;
        i_data_addr = 32'h200; i_data_wdata = 32'h55;
        i_instr_req = 1'b1; i_instr_addr = 32'h300; i_mem_gnt = 1'b1;
        #1;
        chk("lock_gnt_addr", o_mem_addr, 32'h200);
        grants("lock_release", 1'b0, 1'b1, 32'h0A0A);
        tick();
        i_instr_req = 1'b1; i_instr_addr = 32'h300; i_mem_gnt = 1'b1;
        #1;
        chk("after_lock_addr", o_mem_addr, 32'h300);
        grants("after_lock", 1'b1, 1'b0, 32'h33);

        // FIFO full: no request, and no same-cycle bypass on a pop
        tick();
        i_instr_req = 1'b1; i_instr_addr = 32'h304; i_mem_gnt = 1'b1;
        #1;
        chk("full_mem_req", {31'h0, o_mem_req}, 32'h0);
        grants("full", 1'b0, 1'b0, 32'h0);
        tick();
        i_instr_req = 1'b1; i_instr_addr = 32'h304; i_mem_gnt = 1'b1;
        respond("full_pop");
        chk("full_pop_mem_req", {31'h0, o_mem_req}, 32'h0);
        grants("full_pop", 1'b0, 1'b0, 32'h0);
        tick();
        i_instr_req = 1'b1; i_instr_addr = 32'h304; i_mem_gnt = 1'b1;
        #1;
        chk("refill_mem_req", {31'h0, o_mem_req}, 32'h1);
        chk("refill_addr", o_mem_addr, 32'h304);
        grants("refill", 1'b1, 1'b0, 32'h44);
        tick();
        respond("drain_a");
        tick();
        respond("drain_b");

        // Grant I then D; responses come back in order to the right ports
        tick();
        i_instr_req = 1'b1; i_instr_addr = 32'h500; i_mem_gnt = 1'b1;
        grants("order_i", 1'b1, 1'b0, 32'h11);
        tick();
        i_data_req = 1'b1; i_data_addr = 32'h600; i_mem_gnt = 1'b1;
        grants("order_d", 1'b0, 1'b1, 32'h22);
        tick();
        respond("order_r1");
        chk("order_r1_const", o_instr_rdata, 32'h11);
        tick();
        respond("order_r2");
        chk("order_r2_const", o_data_rdata, 32'h22);

        // Stray response sets sticky error; reset clears it and flushes the FIFO
        tick();
        #1;
        chk("err_before", {31'h0, o_err}, 32'h0);
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'hBAD;
        #1;
        chk("stray_instr_rvalid", {31'h0, o_instr_rvalid}, 32'h0);
        chk("stray_data_rvalid", {31'h0, o_data_rvalid}, 32'h0);
        tick();
        #1;
        chk("err_set", {31'h0, o_err}, 32'h1);
        tick();
        i_instr_req = 1'b1; i_instr_addr = 32'h700; i_mem_gnt = 1'b1;
        grants("pre_reset", 1'b1, 1'b0, 32'h77);
        chk("err_sticky", {31'h0, o_err}, 32'h1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        #1;
        chk("err_cleared", {31'h0, o_err}, 32'h0);
        chk("post_reset_mem_req", {31'h0, o_mem_req}, 32'h0);
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'h77;
        #1;
        chk("flushed_instr_rvalid", {31'h0, o_instr_rvalid}, 32'h0);
        chk("flushed_data_rvalid", {31'h0, o_data_rvalid}, 32'h0);
        tick();
        #1;
        chk("flushed_err", {31'h0, o_err}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
